// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared constants, FSM encoding and saturating add for the touch detector
package touch_pkg;

    localparam int NUM_SENSORS = 9;
    localparam int READING_W   = 32;
    localparam int CNT_W       = 4;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        CALIB    = 2'd0,
        CAL_SCAN = 2'd1,
        IDLE     = 2'd2,
        SCAN     = 2'd3
    } touch_state_t;

    // Clamp at all-ones so a huge baseline can never produce a wrapped, tiny threshold
    function automatic logic [READING_W-1:0] sat_add(
        input logic [READING_W-1:0] a,
        input logic [READING_W-1:0] b
    );
        logic [READING_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[READING_W] ? {READING_W{1'b1}} : sum[READING_W-1:0];
    endfunction

endpackage

// File: rtl/touch_sample_tick.sv
// rtl/touch_sample_tick.sv - free-running sample period counter with a one-cycle tick
module touch_sample_tick #(
    parameter int SAMPLE_PERIOD = 50000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_WIDTH = $clog2(SAMPLE_PERIOD);
    localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(SAMPLE_PERIOD - 1);

    logic [CNT_WIDTH-1:0] count;

    // Count 0..SAMPLE_PERIOD-1 and wrap; only reset restarts the phase
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (count == TERMINAL) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == TERMINAL);

endmodule

// File: rtl/capacitive_touch_detector.sv
// rtl/capacitive_touch_detector.sv - baseline calibration and debounced touch detection for 9 pads
module capacitive_touch_detector
    import touch_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 50000,
    parameter int CAL_SHIFT     = 4,
    parameter int THRESHOLD     = 200,
    parameter int DEBOUNCE      = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_SENSORS*READING_W-1:0] readings,
    input  logic                             recal,
    input  logic [NUM_SENSORS-1:0]           clear_hits,
    output logic [NUM_SENSORS-1:0]           touched,
    output logic [NUM_SENSORS-1:0]           hits,
    output logic                             calibrated
);

    localparam int ACC_W     = READING_W + CAL_SHIFT;
    localparam int CAL_CNT_W = CAL_SHIFT + 1;
    localparam logic [CAL_CNT_W-1:0] CAL_SAMPLES   = CAL_CNT_W'(1 << CAL_SHIFT);
    localparam logic [IDX_W-1:0]     LAST_IDX      = IDX_W'(NUM_SENSORS - 1);
    localparam logic [CNT_W-1:0]     DEBOUNCE_CNT  = CNT_W'(DEBOUNCE);
    localparam logic [READING_W-1:0] THRESHOLD_VAL = READING_W'(THRESHOLD);

    touch_state_t state;
    touch_state_t state_next;

    logic                 tick;
    logic [IDX_W-1:0]     idx;
    logic [CAL_CNT_W-1:0] cal_cnt;

    logic [READING_W-1:0] snapshot [NUM_SENSORS];
    logic [READING_W-1:0] baseline [NUM_SENSORS];
    logic [ACC_W-1:0]     acc      [NUM_SENSORS];
    logic [CNT_W-1:0]     cnt      [NUM_SENSORS];

    logic scan_en;
    logic cal_scan_en;
    logic cal_load;
    logic last_idx;

    logic [READING_W-1:0]   snap_sel;
    logic [READING_W-1:0]   base_sel;
    logic [CNT_W-1:0]       cnt_sel;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   touched_sel;
    logic                   raw_touch;
    logic                   disagree;
    logic                   flip;
    logic [NUM_SENSORS-1:0] hit_set;

    touch_sample_tick #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CALIB;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: recal aborts anything and restarts calibration
    always_comb begin
        state_next = state;
        if (recal) begin
            state_next = CALIB;
        end else begin
            case (state)
                CALIB: begin
                    if (cal_cnt == CAL_SAMPLES) begin
                        state_next = IDLE;
                    end else if (tick) begin
                        state_next = CAL_SCAN;
                    end
                end
                CAL_SCAN: if (last_idx) state_next = CALIB;
                IDLE:     if (tick)     state_next = SCAN;
                SCAN:     if (last_idx) state_next = IDLE;
                default:  state_next = CALIB;
            endcase
        end
    end

    // FSM output decode
    always_comb begin
        scan_en     = (state == SCAN);
        cal_scan_en = (state == CAL_SCAN);
        cal_load    = (state == CALIB) && (cal_cnt == CAL_SAMPLES);
        last_idx    = (idx == LAST_IDX);
    end

    // Shared compare/debounce datapath for the sensor currently addressed by idx
    always_comb begin
        snap_sel    = snapshot[idx];
        base_sel    = baseline[idx];
        cnt_sel     = cnt[idx];
        touched_sel = touched[idx];
        cnt_inc     = cnt_sel + 1'b1;
        raw_touch   = snap_sel > sat_add(base_sel, THRESHOLD_VAL);
        disagree    = (raw_touch != touched_sel);
        flip        = disagree && (cnt_inc == DEBOUNCE_CNT);
        hit_set     = '0;
        if (scan_en && flip && raw_touch) begin
            hit_set = NUM_SENSORS'(1) << idx;
        end
    end

    // Freeze all readings on each tick so a scan sees one consistent sample
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SENSORS; i++) snapshot[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < NUM_SENSORS; i++) snapshot[i] <= readings[i*READING_W +: READING_W];
        end
    end

    // Scan index and count of completed calibration scans
    always_ff @(posedge clock) begin
        if (reset || recal) begin
            idx     <= '0;
            cal_cnt <= '0;
        end else if (scan_en || cal_scan_en) begin
            idx <= last_idx ? '0 : idx + 1'b1;
            if (cal_scan_en && last_idx) begin
                cal_cnt <= cal_cnt + 1'b1;
            end
        end
    end

    // Accumulate calibration samples and latch averaged baselines when done
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                acc[i]      <= '0;
                baseline[i] <= '0;
            end
            calibrated <= 1'b0;
        end else if (recal) begin
            for (int i = 0; i < NUM_SENSORS; i++) acc[i] <= '0;
            calibrated <= 1'b0;
        end else begin
            if (cal_scan_en) begin
                acc[idx] <= acc[idx] + ACC_W'(snap_sel);
            end
            if (cal_load) begin
                for (int i = 0; i < NUM_SENSORS; i++) baseline[i] <= acc[i][CAL_SHIFT +: READING_W];
                calibrated <= 1'b1;
            end
        end
    end

    // Debounce counter and touch state update for the scanned sensor
    always_ff @(posedge clock) begin
        if (reset || recal) begin
            for (int i = 0; i < NUM_SENSORS; i++) cnt[i] <= '0;
            touched <= '0;
        end else if (scan_en) begin
            if (!disagree) begin
                cnt[idx] <= '0;
            end else if (flip) begin
                touched[idx] <= raw_touch;
                cnt[idx]     <= '0;
            end else begin
                cnt[idx] <= cnt_inc;
            end
        end
    end

    // Sticky hit flags; a new rising edge beats a same-cycle clear
    always_ff @(posedge clock) begin
        if (reset || recal) begin
            hits <= '0;
        end else begin
            hits <= (hits & ~clear_hits) | hit_set;
        end
    end

endmodule

// File: tb/tb_capacitive_touch_detector.sv
// tb/tb_capacitive_touch_detector.sv - directed self-checking bench for capacitive_touch_detector
module tb_capacitive_touch_detector;

    logic         clock;
    logic         reset;
    logic [287:0] readings;
    logic         recal;
    logic [8:0]   clear_hits;
    logic [8:0]   touched;
    logic [8:0]   hits;
    logic         calibrated;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    capacitive_touch_detector #(
        .SAMPLE_PERIOD(16),
        .CAL_SHIFT    (2),
        .THRESHOLD    (200),
        .DEBOUNCE     (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .readings  (readings),
        .recal     (recal),
        .clear_hits(clear_hits),
        .touched   (touched),
        .hits      (hits),
        .calibrated(calibrated)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to cycle t; we sit 1 time unit after the posedge that starts cycle t
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    // One reset edge; the timer is 0 in the cycle that follows, which becomes cycle 0
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic set_reading(input int i, input logic [31:0] v);
        readings[32*i +: 32] = v;
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < 9; i++) readings[32*i +: 32] = v;
    endtask

    initial begin
        reset      = 1'b1;
        recal      = 1'b0;
        clear_hits = '0;
        readings   = '0;
        set_all(32'd1000);

        // Ticks occur in cycles 16n+15 after reset
        do_reset();
        check_eq("reset_touched", 32'(touched), 32'h0);
        check_eq("reset_hits", 32'(hits), 32'h0);
        check_eq("reset_calibrated", 32'(calibrated), 32'h0);

        // Calibration: ticks 15,31,47,63 -> calibrated at 74
        goto(73);
        check_eq("cal_not_yet", 32'(calibrated), 32'h0);
        goto(74);
        check_eq("cal_rise", 32'(calibrated), 32'h1);
        check_eq("cal_touched", 32'(touched), 32'h0);

        // Detect: sensor 4 at 1201, sensor 5 at 1200 (exactly the threshold)
        set_reading(4, 32'd1201);
        set_reading(5, 32'd1200);
        goto(116);
        check_eq("detect_before", 32'(touched), 32'h0);
        goto(117);
        check_eq("detect_touched", 32'(touched), 32'h010);
        check_eq("detect_hits", 32'(hits), 32'h010);

        // Debounce glitch on sensor 0: two disagreeing ticks then agreement
        set_reading(0, 32'd1500);
        goto(144);
        set_reading(0, 32'd1000);
        goto(160);
        set_reading(0, 32'd1500);
        goto(200);
        check_eq("glitch_ignored", 32'(touched), 32'h010);
        goto(208);
        check_eq("deb_on_before", 32'(touched[0]), 32'h0);
        goto(209);
        check_eq("deb_on", 32'(touched), 32'h011);
        check_eq("deb_on_hits", 32'(hits), 32'h011);
        set_reading(0, 32'd1000);
        goto(256);
        check_eq("deb_off_before", 32'(touched[0]), 32'h1);
        goto(257);
        check_eq("deb_off", 32'(touched), 32'h010);
        check_eq("deb_off_hits", 32'(hits), 32'h011);

        // Clear vs set on sensor 2: ticks 271,287,303, sensor 2 scanned in cycle 306
        set_reading(2, 32'd1500);
        goto(306);
        clear_hits = 9'h004;
        goto(307);
        clear_hits = 9'h004;
        check_eq("set_beats_clear", 32'(hits), 32'h015);
        check_eq("s2_touched", 32'(touched), 32'h014);
        goto(308);
        clear_hits = 9'h001;
        check_eq("clear_s2", 32'(hits), 32'h011);
        goto(309);
        clear_hits = 9'h000;
        check_eq("clear_s0", 32'(hits), 32'h010);
        set_reading(2, 32'd1000);
        goto(355);
        check_eq("s2_release", 32'(touched), 32'h010);
        check_eq("no_hit_on_release", 32'(hits), 32'h010);

        // Recal during SCAN index 5 (tick 367 -> index 5 in cycle 373)
        goto(373);
        check_eq("pre_recal_touched", 32'(touched), 32'h010);
        check_eq("pre_recal_cal", 32'(calibrated), 32'h1);
        recal = 1'b1;
        set_all(32'd3000);
        goto(374);
        recal = 1'b0;
        check_eq("recal_touched", 32'(touched), 32'h0);
        check_eq("recal_hits", 32'(hits), 32'h0);
        check_eq("recal_calibrated", 32'(calibrated), 32'h0);
        // Recalibration ticks 383,399,415,431 -> calibrated at 442
        goto(441);
        check_eq("recal_not_yet", 32'(calibrated), 32'h0);
        goto(442);
        check_eq("recal_done", 32'(calibrated), 32'h1);
        set_reading(1, 32'd3201);
        set_reading(3, 32'd3200);
        goto(481);
        check_eq("b3000_before", 32'(touched), 32'h0);
        goto(482);
        check_eq("b3000_touched", 32'(touched), 32'h002);
        check_eq("b3000_hits", 32'(hits), 32'h002);

        // Saturation: baseline 2^32-150, readings all-ones never touch
        recal = 1'b1;
        set_all(32'hFFFF_FF6A);
        goto(483);
        recal = 1'b0;
        goto(554);
        check_eq("sat_cal", 32'(calibrated), 32'h1);
        set_all(32'hFFFF_FFFF);
        goto(610);
        check_eq("sat_touched", 32'(touched), 32'h0);
        check_eq("sat_hits", 32'(hits), 32'h0);

        // Reset in the middle of calibration restarts the whole sequence
        recal = 1'b1;
        set_all(32'd1000);
        goto(611);
        recal = 1'b0;
        goto(650);
        check_eq("midcal_calibrated", 32'(calibrated), 32'h0);
        do_reset();
        check_eq("rst2_touched", 32'(touched), 32'h0);
        check_eq("rst2_hits", 32'(hits), 32'h0);
        check_eq("rst2_calibrated", 32'(calibrated), 32'h0);
        goto(73);
        check_eq("rst2_cal_not_yet", 32'(calibrated), 32'h0);
        goto(74);
        check_eq("rst2_cal_rise", 32'(calibrated), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/capacitive_touch_detector.md
# capacitive_touch_detector

Converts the 288-bit raw count bus from `capacitive_sensor_array` (9 sensors × 32-bit counts) into debounced per-pad touch state and sticky hit flags for the processor. It sits between the sensor array and the processor's sensor input port. After reset it learns a per-sensor baseline, then periodically snapshots the readings and scans the 9 sensors sequentially through one shared threshold/debounce datapath.

## Interface
- `SAMPLE_PERIOD`, 50000: clock cycles between sample ticks (1 ms at 50 MHz); must be ≥ 10.
- `CAL_SHIFT`, 4: calibration averages 2^CAL_SHIFT samples per sensor.
- `THRESHOLD`, 200: margin above baseline that counts as raw touch.
- `DEBOUNCE`, 3: consecutive disagreeing samples needed to flip touch state; range 1..15.

- `clock`  in  1  Single clock domain; all state updates on its rising edge.
- `reset`  in  1  Synchronous, active-high.
- `readings`  in  288  Sensor i count in bits [32i+31:32i]; a larger count means more capacitance.
- `recal`  in  1  Single-cycle pulse that restarts calibration.
- `clear_hits`  in  9  Per-bit clear of `hits`.
- `touched`  out  9  Debounced touch state per sensor.
- `hits`  out  9  Sticky flag, set on each debounced 0→1 of `touched`.
- `calibrated`  out  1  High once baselines are valid.

## Operation
- FSM states:
  - CALIB: accumulate samples into per-sensor baselines.
  - IDLE: wait for the next tick.
  - SCAN: index 0..8, one sensor per cycle.
  - CAL_SCAN: the calibration variant of SCAN; accumulates instead of comparing.
- Tick timer: counts 0..SAMPLE_PERIOD-1 and free-runs from reset. Tick is asserted at terminal count.
- On tick, the 288-bit `readings` is captured into a snapshot register. The scan uses only the snapshot, so input changes mid-scan are ignored.
- Calibration:
  - Each of 9 accumulators is (32+CAL_SHIFT) bits, cleared on entry.
  - CAL_SCAN adds snapshot[i] to acc[i].
  - After 2^CAL_SHIFT scans, baseline[i] = acc[i] >> CAL_SHIFT, `calibrated` rises, and the FSM goes to IDLE.
- Normal scan:
  - Raw touch for sensor i is `snapshot[i] > sat(baseline[i] + THRESHOLD)`. The add saturates at 2^32−1, so raw touch is impossible when saturated.
- Debounce, per sensor, with a 4-bit counter cnt[i]:
  - raw == touched[i]: cnt ← 0.
  - raw differs and cnt+1 == DEBOUNCE: touched[i] flips and cnt ← 0.
  - Otherwise: cnt increments.
- Hits: a 0→1 flip of touched[i] sets hits[i]. `clear_hits[i]` clears it. If set and clear occur in the same cycle, set wins. `clear_hits` is honoured in every state.
- `recal`, sampled in any state:
  - Clears `touched`, `hits`, all cnt, all accumulators and `calibrated`.
  - FSM → CALIB; any scan in progress is aborted.
  - The tick timer is not reset.
- Ticks while in SCAN cannot occur, because SAMPLE_PERIOD ≥ 10.

## Timing
- Reset values:
  - Outputs: `touched`=0, `hits`=0, `calibrated`=0.
  - FSM=CALIB, timer=0; cnt, accumulators, baselines and snapshot all 0.
- Tick at cycle t: the snapshot is valid from t+1. SCAN processes sensor i in cycle t+1+i, and the result is visible on `touched[i]`/`hits[i]` from t+2+i. The FSM is back in IDLE at t+10.
- `calibrated` rises 2 cycles after the last calibration scan's sensor-8 cycle, i.e. at t_last+11.
- Minimum touch-detect latency is DEBOUNCE ticks, plus up to SAMPLE_PERIOD cycles of phase, plus 2+i cycles.
- `clear_hits` takes effect on the next edge and is visible 1 cycle later.
- `recal` takes effect on the next edge.
- `reset` overrides `recal`, `clear_hits` and a pending set.

## Structure
- Shared package `touch_pkg` holds:
  - NUM_SENSORS=9, READING_W=32, CNT_W=4.
  - FSM state encoding: CALIB, CAL_SCAN, IDLE, SCAN.
  - Helper function for the saturating add.
- One sub-module, `touch_sample_tick`: the SAMPLE_PERIOD counter emitting a 1-cycle `tick`, with sync reset.
- Everything else lives in the top module: FSM, 4-bit scan index, snapshot, baseline and cnt arrays, and a single shared compare/debounce datapath muxed by the index.

## Test plan
All scenarios use SAMPLE_PERIOD=16, CAL_SHIFT=2, THRESHOLD=200, DEBOUNCE=3.
- **Calibration:** hold all readings at 1000 from reset → `calibrated` rises after 4 ticks + 11 cycles. All baselines are 1000 and `touched`=0.
- **Detect:** after calibration, set sensor 4 to 1201 → touched[4] and hits[4] rise during the 3rd tick's scan at t+6. At 1200 (not > 1200), no detection ever occurs.
- **Debounce glitch:** sensor 0 reads 1500 for 2 ticks, then 1000 → touched[0] stays 0. Then 1500 for 3 ticks → touched[0]=1. Then 1000 for 3 ticks → touched[0]=0, hits[0] remains 1.
- **Clear vs set:** assert clear_hits[2] in the exact cycle hits[2] is being set → hits[2]=1. Assert clear_hits[2] one cycle later → hits[2]=0.
- **Recal mid-scan:** pulse recal during SCAN at index 5 with touched=9'h010 → next cycle `touched`=0, `hits`=0, `calibrated`=0. Recalibration at readings 3000 gives baseline 3000.
- **Saturation and reset:** a baseline of 2^32−150 gives no touch even at 2^32−1. Asserting `reset` mid-CALIB returns all outputs to 0 on the next edge.
